// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux block.
// The STREAM_DEMUX_CNT_EN build option lives in the top module, not here.
package stream_demux_pkg;

  localparam int MAX_OUT   = 16;
  localparam int MAX_SEL_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Select width, never narrower than one bit even for tiny NUM_OUT.
  function automatic int sel_w(input int num_out);
    return (num_out <= 2) ? 1 : $clog2(num_out);
  endfunction

  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return MAX_OUT'(1) << idx;
  endfunction

endpackage

// File: rtl/stream_demux_cnt.sv
// Wrapping count of completed output transfers.
// Only instantiated when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Plain modular add; wrap to zero falls out of the fixed width.
  assign cnt_d = inc_i ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a single holding register.
// Build option: define STREAM_DEMUX_CNT_EN to enable the out_cnt transfer counter.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_OUT = 2,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = sel_w(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               out_err,
  output logic [CNT_W-1:0]   out_cnt
);

  state_e             state_q;
  logic [DATA_W-1:0]  data_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_OUT-1:0] valid_q;
  logic               err_q;

  logic [MAX_SEL_W:0] sel_ext;
  logic               sel_legal;
  logic [NUM_OUT-1:0] valid_d;
  logic               out_fire;
  logic               in_fire;

  // Widened compare so the legality test stays meaningful for every NUM_OUT.
  assign sel_ext   = (MAX_SEL_W+1)'(in_sel);
  assign sel_legal = sel_ext < (MAX_SEL_W+1)'(NUM_OUT);
  assign valid_d   = NUM_OUT'(onehot(MAX_SEL_W'(in_sel)));

  // valid_q is one-hot on sel_q while FULL, so this equals out_ready[sel_q].
  assign out_fire = |(valid_q & out_ready);
  assign in_ready = (state_q == EMPTY) || out_fire;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= in_fire && !sel_legal;
      unique case (state_q)
        EMPTY: begin
          if (in_fire && sel_legal) begin
            state_q <= FULL;
            data_q  <= in_data;
            sel_q   <= in_sel;
            valid_q <= valid_d;
          end
        end
        FULL: begin
          if (out_fire) begin
            if (in_fire && sel_legal) begin
              data_q  <= in_data;
              sel_q   <= in_sel;
              valid_q <= valid_d;
            end else begin
              state_q <= EMPTY;
              valid_q <= '0;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= '0;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_err   = err_q;

`ifdef STREAM_DEMUX_CNT_EN
  stream_demux_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_fire),
    .cnt_o (out_cnt)
  );
`else
  assign out_cnt = '0;
`endif

endmodule
